// File: rtl/hex_arb_pkg.sv
// hex_arb_pkg: FSM encoding and display constants shared by the arbiter blocks
package hex_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  localparam int NDISP = 6;
  localparam int AW = 3;
  localparam logic [6:0] BLANK_DEF = 7'h7F;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, searching upward from ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);
  // descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[PW'((int'(ptr) + i) % NREQ)]) gnt = NREQ'(1) << ((int'(ptr) + i) % NREQ);
  end
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin arbitration of display writes onto six
// registered 7-segment outputs, one transaction every three cycles
module hex_display_arbiter import hex_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter logic [6:0] BLANK = BLANK_DEF
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  addr,
  input  logic [7*NREQ-1:0]  data,
  input  logic               clr,
  input  logic               hold,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
);
  localparam int PW = $clog2(NREQ);
  state_t state, nxt;
  logic [PW-1:0] ptr, win, win_idx, ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic [6:0] hex_q [NDISP];
  logic [AW-1:0] a;
  logic [6:0] d;
  logic err_q, go, ok;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (.req(req), .ptr(ptr), .gnt(gnt));
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) win_idx = PW'(i);
    ptr_nxt = win_idx == PW'(NREQ - 1) ? '0 : win_idx + PW'(1);
    go = !clr && !hold && |req;
    nxt = state == IDLE ? (go ? GRANT : IDLE) : state == GRANT ? DONE : IDLE;
  end
  assign a = addr[AW*int'(win) +: AW];
  assign d = data[7*int'(win) +: 7];
  assign ok = a < AW'(NDISP);
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NDISP; i++) hex_q[i] <= BLANK;
    end else begin
      state <= nxt;
      if (state == IDLE && clr)
        for (int i = 0; i < NDISP; i++) hex_q[i] <= BLANK;
      if (state == IDLE && go) begin
        win <= win_idx;
        ptr <= ptr_nxt;
      end
      if (state == GRANT) begin
        err_q <= !ok;
        if (ok) hex_q[a] <= d;
      end
    end
  end
  assign ack = state == DONE ? NREQ'(1) << win : '0;
  assign err = state == DONE && err_q;
  assign busy = state != IDLE;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed scenarios with hand-computed expectations
module tb_hex_display_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [11:0] addr = '0;
  logic [27:0] data = '0;
  logic clr = 1'b0, hold = 1'b0;
  logic [3:0] ack;
  logic err, busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0] hex_w [6];
  logic [6:0] exp_hex [6];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hex_display_arbiter dut (
    .CLOCK_50(clk), .Resetn(rst_n), .req(req), .addr(addr), .data(data),
    .clr(clr), .hold(hold), .ack(ack), .err(err), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );
  assign hex_w[0] = HEX0;
  assign hex_w[1] = HEX1;
  assign hex_w[2] = HEX2;
  assign hex_w[3] = HEX3;
  assign hex_w[4] = HEX4;
  assign hex_w[5] = HEX5;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; req = '0; clr = 1'b0; hold = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl ack=%b err=%b busy=%b required 0000/0/0", ack, err, busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hex_w[i] !== 7'h7F) begin failures++; $display("FAIL reset_hex%0d got %h required 7f", i, hex_w[i]); end
    end
  endtask
  task automatic test_single();
    req = 4'b0001; addr[2:0] = 3'd2; data[6:0] = 7'h40;
    step();
    checks++;
    if (busy !== 1'b1 || ack !== 4'b0) begin failures++; $display("FAIL single_grant busy=%b ack=%b required 1/0000", busy, ack); end
    step();
    exp_hex[2] = 7'h40;
    checks++;
    if (ack !== 4'b0001 || err !== 1'b0) begin failures++; $display("FAIL single_ack ack=%b err=%b required 0001/0", ack, err); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hex_w[i] !== exp_hex[i]) begin failures++; $display("FAIL single_hex%0d got %h required %h", i, hex_w[i], exp_hex[i]); end
    end
    req = '0;
    step();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle ack=%b busy=%b required 0000/0", ack, busy); end
  endtask
  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    do_reset();
    addr = {3'd3, 3'd2, 3'd1, 3'd0};
    data = {7'h08, 7'h04, 7'h02, 7'h01};
    req = 4'b1111;
    for (int c = 1; c <= 14; c++) begin
      step();
      e = (c % 3 == 2) ? 4'(1 << order[c / 3]) : 4'b0;
      checks++;
      if (ack !== e) begin failures++; $display("FAIL rr_cycle%0d ack=%b required %b", c, ack, e); end
    end
    req = '0;
    step();
    exp_hex[0] = 7'h01; exp_hex[1] = 7'h02; exp_hex[2] = 7'h04; exp_hex[3] = 7'h08;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hex_w[i] !== exp_hex[i]) begin failures++; $display("FAIL rr_hex%0d got %h required %h", i, hex_w[i], exp_hex[i]); end
    end
  endtask
  task automatic test_bad_addr();
    req = 4'b0010; addr[5:3] = 3'd7; data[13:7] = 7'h55;
    step(); step();
    checks++;
    if (ack !== 4'b0010 || err !== 1'b1) begin failures++; $display("FAIL bad_ack ack=%b err=%b required 0010/1", ack, err); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hex_w[i] !== exp_hex[i]) begin failures++; $display("FAIL bad_hex%0d got %h required %h", i, hex_w[i], exp_hex[i]); end
    end
    req = 4'b0100; addr[8:6] = 3'd5; data[20:14] = 7'h2A;
    step(); step(); step();
    exp_hex[5] = 7'h2A;
    checks++;
    if (ack !== 4'b0100 || err !== 1'b0 || HEX5 !== 7'h2A) begin
      failures++;
      $display("FAIL addr5 ack=%b err=%b hex5=%h required 0100/0/2a", ack, err, HEX5);
    end
    req = '0;
    step();
  endtask
  task automatic test_clr();
    clr = 1'b1; req = 4'b0100; addr[8:6] = 3'd4; data[20:14] = 7'h3C;
    step();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin failures++; $display("FAIL clr_nogrant busy=%b ack=%b required 0/0000", busy, ack); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hex_w[i] !== 7'h7F) begin failures++; $display("FAIL clr_hex%0d got %h required 7f", i, hex_w[i]); end
    end
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clr_regrant busy=%b required 1", busy); end
    step();
    exp_hex[4] = 7'h3C;
    checks++;
    if (ack !== 4'b0100 || HEX4 !== 7'h3C) begin failures++; $display("FAIL clr_ack ack=%b hex4=%h required 0100/3c", ack, HEX4); end
    req = '0;
    step();
  endtask
  task automatic test_hold();
    hold = 1'b1; req = 4'b1000; addr[11:9] = 3'd1; data[27:21] = 7'h12;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0) begin failures++; $display("FAIL hold_cycle%0d busy=%b ack=%b required 0/0000", c, busy, ack); end
    end
    hold = 1'b0;
    step();
    clr = 1'b1; hold = 1'b1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hold_release busy=%b required 1", busy); end
    step();
    clr = 1'b0; hold = 1'b0;
    exp_hex[1] = 7'h12;
    checks++;
    if (ack !== 4'b1000 || HEX1 !== 7'h12 || HEX4 !== 7'h3C) begin
      failures++;
      $display("FAIL hold_ack ack=%b hex1=%h hex4=%h required 1000/12/3c", ack, HEX1, HEX4);
    end
    req = '0;
    step();
  endtask
  task automatic test_reset_mid();
    req = 4'b0010; addr[5:3] = 3'd0; data[13:7] = 7'h66;
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_grant busy=%b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0 || HEX1 !== 7'h7F) begin
      failures++;
      $display("FAIL mid_async busy=%b ack=%b hex1=%h required 0/0000/7f", busy, ack, HEX1);
    end
    step();
    checks++;
    if (ack !== 4'b0 || HEX0 !== 7'h7F) begin failures++; $display("FAIL mid_noack ack=%b hex0=%h required 0000/7f", ack, HEX0); end
    rst_n = 1'b1;
    req = 4'b1111; addr = {3'd3, 3'd2, 3'd1, 3'd0}; data = {7'h08, 7'h04, 7'h02, 7'h01};
    step(); step();
    checks++;
    if (ack !== 4'b0001 || HEX0 !== 7'h01) begin failures++; $display("FAIL mid_ptr0 ack=%b hex0=%h required 0001/01", ack, HEX0); end
    req = '0;
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_addr();
    test_clr();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
